// File: rtl/btn_debounce_multi.sv
// N-channel pushbutton conditioner: sync, tick-sampled debounce, edge/long-press pulses.
// Optional auto-repeat is built only when BTN_DEBOUNCE_REPEAT_EN is defined.
module btn_debounce_multi #(
  parameter int N_CH         = 4,
  parameter int DIV          = 100,
  parameter int STABLE       = 4,
  parameter int LONG_TICKS   = 50000,
  parameter int REPEAT_TICKS = 10000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_long,
  output logic [N_CH-1:0] btn_repeat
);

  localparam int DW = $clog2(DIV);
  localparam int CW = $clog2(STABLE);
  localparam int HW = $clog2(LONG_TICKS + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
`endif

  if (N_CH < 1 || DIV < 2 || STABLE < 2 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("btn_debounce_multi: parameter out of range");
  end

  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          s1, s2;
    logic          level, level_d, level_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [HW-1:0] hold;
    logic          long_q;
    logic          stay_high, hold_sat;

    // Any agreeing sample restarts the run, so only STABLE consecutive differing samples flip level.
    always_comb begin
      level_nxt = level;
      cnt_nxt   = cnt;
      if (tick) begin
        if (s2 == level) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          level_nxt = s2;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end

    // Ticks only count while level was high and is staying high; the falling tick clears instead.
    assign stay_high = level & level_nxt;
    assign hold_sat  = (hold == HOLD_MAX);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1      <= 1'b0;
        s2      <= 1'b0;
        level   <= 1'b0;
        level_d <= 1'b0;
        cnt     <= '0;
        hold    <= '0;
        long_q  <= 1'b0;
      end else begin
        s1      <= btn_in[i];
        s2      <= s1;
        level   <= level_nxt;
        level_d <= level;
        cnt     <= cnt_nxt;
        long_q  <= 1'b0;
        if (!stay_high) begin
          hold <= '0;
        end else if (tick && !hold_sat) begin
          hold   <= hold + HW'(1);
          long_q <= (hold == HOLD_LAST);
        end
      end
    end

    assign btn_level[i] = level;
    assign btn_rise[i]  = level & ~level_d;
    assign btn_fall[i]  = ~level & level_d;
    assign btn_long[i]  = long_q;

`ifdef BTN_DEBOUNCE_REPEAT_EN
    logic [RW-1:0] rep;
    logic          rep_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rep   <= '0;
        rep_q <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        if (!stay_high || !hold_sat) begin
          rep <= '0;
        end else if (tick) begin
          if (rep == REP_LAST) begin
            rep   <= '0;
            rep_q <= 1'b1;
          end else begin
            rep <= rep + RW'(1);
          end
        end
      end
    end

    assign btn_repeat[i] = rep_q;
`else
    assign btn_repeat[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: tick-level behavioural model compared every cycle,
// directed scenarios with literal timing expectations, then randomized button traffic.
module tb_btn_debounce_multi;

  localparam int N_CH         = 2;
  localparam int DIV          = 4;
  localparam int STABLE       = 3;
  localparam int LONG_TICKS   = 8;
  localparam int REPEAT_TICKS = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N_CH-1:0] btn_in = '0;
  logic [N_CH-1:0] btn_level, btn_rise, btn_fall, btn_long, btn_repeat;

  int vectors     = 0;
  int miscompares = 0;

  btn_debounce_multi #(
    .N_CH(N_CH), .DIV(DIV), .STABLE(STABLE),
    .LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
    .btn_long(btn_long), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edge count since reset gives the tick; the filter input is btn_in two edges back.
  int              m_edge = 0;
  logic            m_tick = 1'b0;
  logic [N_CH-1:0] m_d1 = '0, m_d2 = '0, m_samp = '0, m_old = '0;
  logic [N_CH-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_long = '0, m_rep = '0;
  int              m_run  [N_CH];
  int              m_hold [N_CH];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_edge = 0; m_d1 = '0; m_d2 = '0;
      m_level = '0; m_rise = '0; m_fall = '0; m_long = '0; m_rep = '0;
      for (int c = 0; c < N_CH; c++) begin m_run[c] = 0; m_hold[c] = 0; end
    end else begin
      m_tick = ((m_edge % DIV) == (DIV - 1));
      m_samp = m_d2;
      m_d2   = m_d1;
      m_d1   = btn_in;
      m_old  = m_level;
      m_long = '0;
      m_rep  = '0;
      for (int c = 0; c < N_CH; c++) begin
        if (m_tick) begin
          if (m_samp[c] != m_level[c]) begin
            m_run[c]++;
            if (m_run[c] == STABLE) begin m_level[c] = m_samp[c]; m_run[c] = 0; end
          end else begin
            m_run[c] = 0;
          end
        end
        if (!m_level[c]) begin
          m_hold[c] = 0;
        end else if (m_tick && m_old[c]) begin
          m_hold[c]++;
          m_long[c] = (m_hold[c] == LONG_TICKS);
`ifdef BTN_DEBOUNCE_REPEAT_EN
          m_rep[c] = (m_hold[c] > LONG_TICKS) && (((m_hold[c] - LONG_TICKS) % REPEAT_TICKS) == 0);
`endif
        end
      end
      m_rise = m_level & ~m_old;
      m_fall = ~m_level & m_old;
      m_edge++;
    end
  end

  always @(negedge clk) begin
    chk("level",  32'(btn_level),  32'(m_level));
    chk("rise",   32'(btn_rise),   32'(m_rise));
    chk("fall",   32'(btn_fall),   32'(m_fall));
    chk("long",   32'(btn_long),   32'(m_long));
    chk("repeat", 32'(btn_repeat), 32'(m_rep));
  end

  task automatic wait_bit(input string name, input int ch, input logic val, input int max, output int n);
    n = 0;
    while (btn_level[ch] !== val && n < max) begin
      @(negedge clk);
      n++;
    end
    if (btn_level[ch] !== val) chk(name, 32'(btn_level[ch]), 32'(val));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_level"},  32'(btn_level),  0);
    chk({name, "_rise"},   32'(btn_rise),   0);
    chk({name, "_fall"},   32'(btn_fall),   0);
    chk({name, "_long"},   32'(btn_long),   0);
    chk({name, "_repeat"}, 32'(btn_repeat), 0);
  endtask

  task automatic measure_long(input int window, output int cnt, output int at);
    cnt = 0;
    at  = -1;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (btn_long[1]) begin cnt++; if (at < 0) at = k; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, cnt, act, longs, long_at, reps, rep_first, dur;

    // Reset held with both buttons pressed.
    btn_in = 2'b11;
    repeat (10) @(negedge clk);
    chk_all_zero("in_reset");
    #2 rst = 1'b1;
    n = 0;
    cnt = 0;
    while (btn_level !== 2'b11 && n < 20) begin
      @(negedge clk);
      n++;
      if (btn_rise == 2'b11) cnt++;
    end
    chk("reset_release_latency", 32'(n), 12);
    repeat (6) begin @(negedge clk); if (btn_rise != 2'b00) cnt++; end
    chk("reset_release_rise_once", 32'(cnt), 1);
    btn_in = 2'b00;
    wait_bit("release_ch0", 0, 1'b0, 30, n);
    wait_bit("release_ch1", 1, 1'b0, 30, n);
    repeat (8) @(negedge clk);

    // Clean press on channel 0.
    btn_in[0] = 1'b1;
    wait_bit("press_timeout", 0, 1'b1, 30, n);
    chk("press_latency_min", 32'(n >= 11), 1);
    chk("press_latency_max", 32'(n <= 14), 1);
    chk("press_rise_on", 32'(btn_rise[0]), 1);
    @(negedge clk);
    chk("press_rise_width", 32'(btn_rise[0]), 0);
    repeat (78) @(negedge clk);
    btn_in[0] = 1'b0;
    wait_bit("press_release", 0, 1'b0, 30, n);
    repeat (8) @(negedge clk);

    // Bounce: each value lasts exactly two ticks.
    act = 0;
    for (int t = 0; t < 10; t++) begin
      btn_in[0] = ~btn_in[0];
      repeat (8) begin
        @(negedge clk);
        if (btn_level[0] | btn_rise[0] | btn_fall[0]) act++;
      end
    end
    btn_in[0] = 1'b0;
    repeat (20) begin @(negedge clk); if (btn_level[0] | btn_rise[0] | btn_fall[0]) act++; end
    chk("bounce_quiet", 32'(act), 0);

    // Long press and repeat on channel 1.
    btn_in[1] = 1'b1;
    wait_bit("long_press", 1, 1'b1, 30, n);
    longs = 0; long_at = -1; reps = 0; rep_first = -1;
    for (int k = 1; k <= 82; k++) begin
      @(negedge clk);
      if (btn_long[1])   begin longs++; if (long_at < 0) long_at = k; end
      if (btn_repeat[1]) begin reps++;  if (rep_first < 0) rep_first = k; end
    end
    chk("long_once", 32'(longs), 1);
    chk("long_at_tick8", 32'(long_at), 32);
`ifdef BTN_DEBOUNCE_REPEAT_EN
    chk("repeat_count", 32'(reps), 3);
    chk("repeat_first_tick12", 32'(rep_first), 48);
`else
    chk("repeat_none", 32'(reps), 0);
`endif
    btn_in[1] = 1'b0;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (btn_fall[1]) cnt++; end
    chk("long_release_fall_once", 32'(cnt), 1);
    repeat (8) @(negedge clk);

    // Release at hold tick 10, then a fresh press restarts the hold count.
    btn_in[1] = 1'b1;
    wait_bit("rel10_press", 1, 1'b1, 30, n);
    repeat (40) @(negedge clk);
    btn_in[1] = 1'b0;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (btn_fall[1]) cnt++; end
    chk("rel10_fall_once", 32'(cnt), 1);
    chk("rel10_level_low", 32'(btn_level[1]), 0);
    repeat (8) @(negedge clk);
    btn_in[1] = 1'b1;
    wait_bit("repress", 1, 1'b1, 30, n);
    measure_long(40, longs, long_at);
    chk("repress_long_once", 32'(longs), 1);
    chk("repress_long_at_tick8", 32'(long_at), 32);
    btn_in[1] = 1'b0;
    wait_bit("repress_release", 1, 1'b0, 30, n);
    repeat (8) @(negedge clk);

    // Reset at hold tick 5: outputs clear at once, no fall afterwards.
    btn_in[1] = 1'b1;
    wait_bit("midhold_press", 1, 1'b1, 30, n);
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("midhold_reset");
    btn_in = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    cnt = 0;
    repeat (30) begin @(negedge clk); if (btn_fall != 2'b00 || btn_rise != 2'b00) cnt++; end
    chk("midhold_no_edges", 32'(cnt), 0);

    // Randomized traffic, including long holds and occasional resets.
    for (int it = 0; it < 300; it++) begin
      btn_in = N_CH'($urandom);
      if ($urandom_range(0, 7) == 0) dur = $urandom_range(60, 160);
      else                           dur = $urandom_range(1, 40);
      repeat (dur) @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
      end
    end

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised N-channel button conditioner that sits between the raw board pushbuttons and the control FSMs. Each channel is synchronised, then filtered symmetrically on press and release from a shared sample-tick generator. Each channel produces a clean level plus one-clock press, release and long-press pulses, with optional auto-repeat. The block runs entirely in the `clk` domain and generates no derived clocks.

## Interface
- `N_CH`, 4: number of independent button channels (≥1).
- `DIV`, 100: `clk` cycles per sample tick (≥2).
- `STABLE`, 4: consecutive identical differing samples required to change level (≥2).
- `LONG_TICKS`, 50000: sample ticks of continuous press before the long-press pulse (≥1).
- `REPEAT_TICKS`, 10000: sample ticks between repeat pulses after a long press (≥1).
- `clk` in 1: system clock; all logic is clocked on its rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `btn_in` in N_CH: raw asynchronous button inputs, active-high.
- `btn_level` out N_CH: debounced level.
- `btn_rise` out N_CH: one-clk pulse on a debounced 0→1 transition.
- `btn_fall` out N_CH: one-clk pulse on a debounced 1→0 transition.
- `btn_long` out N_CH: one-clk pulse when a press reaches `LONG_TICKS`.
- `btn_repeat` out N_CH: one-clk auto-repeat pulse; constant 0 when the repeat feature is compiled out.

## Operation
- **Synchroniser:** two flops per channel (`s1` → `s2`), reset to 0.
- **Tick generator:** one counter, `$clog2(DIV)` bits, counts 0..DIV-1 and wraps. `tick` is high for exactly one clk when the counter equals DIV-1. All channels share this single tick.
- **Filter:** per-channel counter `cnt` of `$clog2(STABLE)` bits. On a tick:
  - if `s2 == level`, `cnt` ← 0;
  - otherwise, if `cnt == STABLE-1`, then `level` ← `s2` and `cnt` ← 0;
  - otherwise `cnt` ← `cnt`+1.
  - Between ticks, `cnt` and `level` hold.
  - A single agreeing sample restarts the count, so bounces shorter than `STABLE` ticks never reach `level`.
- **Edges:** `level_d` is `level` delayed one clk.
  - `btn_rise` = `level & ~level_d`.
  - `btn_fall` = `~level & level_d`.
  - Each is exactly one clk wide.
- **Hold counter:** per channel, `$clog2(LONG_TICKS+1)` bits.
  - Cleared whenever `level` = 0.
  - Otherwise it increments on each tick and saturates at `LONG_TICKS`.
  - `btn_long` pulses for one clk on the tick where it transitions to `LONG_TICKS`. It fires at most once per press.
- **Repeat** (feature enabled): per-channel counter of `$clog2(REPEAT_TICKS)` bits.
  - Cleared while `level` = 0 or hold < `LONG_TICKS`.
  - Once saturated, it counts ticks. On reaching `REPEAT_TICKS`-1 it wraps to 0 and pulses `btn_repeat` for one clk.
  - The first repeat comes `REPEAT_TICKS` ticks after `btn_long`.
- **Channel independence:** channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.

## Timing
- **Reset values:** on `rst` = 0, all outputs, synchroniser flops, counters, `level` and `level_d` go to 0 immediately (asynchronously).
- **Reset mid-press:** if a button is held across reset release, it is treated as a new press. `btn_rise` fires after filtering, and the hold count restarts from 0.
- **Press/release latency:** from an `btn_in` change that then stays stable, to `btn_level` change:
  - minimum 2 + (STABLE-1)·DIV + 1 clk;
  - maximum 2 + STABLE·DIV clk.
- **Edge pulses:** `btn_rise`/`btn_fall` are coincident with the first clk of the new `btn_level` value.
- **Long press:** `btn_long` asserts on the `clk` edge following the `LONG_TICKS`-th tick counted with `level` = 1.
- **Release during long/repeat:** clears hold and repeat counters on the tick where `level` falls. No `btn_long` or `btn_repeat` is issued in that cycle.
- **Release before `LONG_TICKS`:** produces `btn_fall` only.

## Configuration
- **Macro `BTN_DEBOUNCE_REPEAT_EN`.**
- **Defined:** repeat counters are instantiated and `btn_repeat` behaves as described above.
- **Undefined:** no repeat logic is synthesised and `btn_repeat` is tied to N_CH'b0. All other behaviour is identical.

## Test plan
Bench parameters: N_CH=2, DIV=4, STABLE=3, LONG_TICKS=8, REPEAT_TICKS=4.

- **Reset:** hold `rst` = 0 for 10 clk with `btn_in` = 2'b11 → all outputs 0. After release, `btn_level` = 2'b11 within 2+12 clk, and `btn_rise` = 2'b11 pulses once.
- **Clean press:** `btn_in[0]` 0→1 held 20 ticks → `btn_level[0]` rises after 11–14 clk, `btn_rise[0]` is one clk wide, channel 1 outputs stay 0.
- **Bounce:** toggle `btn_in[0]` every 2 ticks for 20 ticks → `btn_level[0]` stays 0 and no pulses occur.
- **Long press / repeat:** hold channel 1 for 20 ticks after `level` rises → `btn_long[1]` pulses once at hold tick 8. With the macro, `btn_repeat[1]` pulses at ticks 12, 16 and 20. Without the macro, no repeat pulses occur.
- **Release:** release channel 1 at hold tick 10 → one `btn_fall[1]` pulse, counters cleared. A new press restarts the hold count, and `btn_long` fires again at tick 8.
- **Reset mid-hold:** assert `rst` at hold tick 5 → outputs go 0 in the same cycle. No `btn_fall` is emitted after reset release.
